mux_rr_sel_sched: RTL and testbench
===================================

Name: mux_rr_sel_sched

Overview:
- Round-robin scheduler that sits directly upstream of the 4:1 mux (mux_4to1) and drives its 2-bit `sel`.
- Arbitrates four request lines and holds a grant for a configurable burst of accepted beats.
- Exposes a valid/ready handshake toward the consumer of the mux output.
- Guarantees fair, starvation-free sharing of the mux between four sources.

Parameters:
- BURST_LEN, 4: accepted beats per grant before forced rotation; legal range 1..255.
- CNT_W, $clog2(BURST_LEN+1): width of the beat counter. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; deassertion is synchronous to clk at system level.
- req  input  4  req[i]=1: source i (mux in(i+1)) has data.
- out_ready  input  1  downstream accepts the mux output this cycle.
- sel  output  2  mux select, registered; encodes the granted channel.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- sel_valid  output  1  mux output is valid this cycle.
- burst_done  output  1  one-cycle pulse, registered; asserted the cycle after the final beat of a full burst.

Behaviour:
- Reset (async, active-high), all values below: state=IDLE, sel=2'b00, grant=4'b0000, sel_valid=0, burst_done=0, ptr=0, beat_cnt=0.
- State machine: IDLE, GRANT.
- IDLE, req==0: stay in IDLE; outputs hold idle values.
- IDLE, req!=0:
  - Pick the first set bit of req, scanning ptr, ptr+1, ... with mod-4 wrap.
  - Next edge: sel=index, grant=onehot(index), beat_cnt=0, state=GRANT.
  - Latency from req assertion to grant is 1 cycle.
- GRANT:
  - sel_valid = req[sel] (combinational from req; registered state gates it).
  - sel and grant are stable for the whole state.
  - Handshake = sel_valid & out_ready. Each handshake increments beat_cnt.
- Burst complete: handshake while beat_cnt==BURST_LEN-1. Next edge:
  - state=IDLE, grant=0, ptr=sel+1 (2-bit wrap: 3 -> 0), burst_done=1 for one cycle.
- Early release: req[sel]==0 in GRANT with no handshake possible. Next edge:
  - state=IDLE, grant=0, ptr=sel+1, burst_done=0.
  - The partial burst is abandoned.
- Rotation always passes through IDLE, giving one bubble cycle between grants. This is intentional so sel changes only while sel_valid=0.
- sel holds its last value in IDLE. It is not cleared, so the mux output stays glitch-free.
- A requester that loses arbitration is not latched. It must hold req until granted.
- Other req bits changing during GRANT have no effect until the return to IDLE.
- Fairness: with all four req held high, the grant order is 0,1,2,3,0,... Each channel gets exactly BURST_LEN beats per turn.
- BURST_LEN=1: every handshake rotates.
- out_ready held low: the grant holds indefinitely. There is no timeout.
- rst asserted mid-burst: immediate return to reset values; in-flight beat count is discarded.

Decomposition:
- Package mux_sched_pkg holds:
  - NUM_CH=4, SEL_W=2.
  - typedef enum logic {IDLE, GRANT} sched_state_t.
- Sub-module rr_pick4: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0] (rotating priority pick).
  - Verify standalone for all 64 req/ptr combinations.

Test Plan:
- Reset: assert rst mid-sequence with req=4'b1111 -> sel=0, grant=0, sel_valid=0, burst_done=0 asynchronously.
- Single requester, BURST_LEN=4: req=4'b0100, out_ready=1 ->
  - grant=4'b0100 and sel=2 one cycle later.
  - 4 handshakes, then burst_done pulse, then 1 IDLE cycle, then re-grant of channel 2.
- All requesting: req=4'b1111, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts exactly 4 handshakes with 1 bubble between.
- Backpressure: channel 1 granted, out_ready=0 for 10 cycles -> sel_valid=1, grant stable, beat_cnt frozen. Burst completes only after 4 ready cycles.
- Early release: channel 3 granted, drop req[3] after 2 beats ->
  - sel_valid falls the same cycle; IDLE next edge; burst_done=0.
  - ptr=0, so req=4'b0011 then grants channel 0.
- Wrap and skip: ptr=3, req=4'b0010 -> channel 1 granted (wrap past 3, 0); sel=1.

Source files
------------

// File: rtl/mux_rr_sel_sched_pkg.sv
// Shared types and constants for the round-robin mux select scheduler.
package mux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_rr_sel_sched_if.sv
// Request/grant/handshake bundle between the sources, the scheduler and the mux consumer.
interface mux_sched_if;
    import mux_sched_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] grant;
    logic              sel_valid;
    logic              burst_done;

    // Environment side: drives requests and consumer readiness.
    modport master (
        output req, out_ready,
        input  sel, grant, sel_valid, burst_done
    );

    // Scheduler side.
    modport slave (
        input  req, out_ready,
        output sel, grant, sel_valid, burst_done
    );

endinterface

// File: rtl/mux_rr_sel_sched_rr_pick4.sv
// Rotating-priority pick: first set request at or after ptr, wrapping mod 4.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        found = 1'b0;
        idx   = ptr;
        // Scan from farthest to nearest so the candidate closest to ptr wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_sel_sched.sv
// Round-robin scheduler driving the 4:1 mux select, granting bursts of BURST_LEN accepted beats.
module mux_rr_sel_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    mux_sched_if.slave  s_if
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    sched_state_t      r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_ptr;
    logic [NUM_CH-1:0] r_grant;
    logic              r_burst_done;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_found;
    logic [SEL_W-1:0]  w_idx;
    logic              w_req_sel;
    logic              w_sel_valid;
    logic              w_handshake;

    rr_pick4 u_pick (
        .req   (s_if.req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Valid follows the granted request live so a dropped request stops the beat immediately.
    assign w_req_sel   = s_if.req[r_sel];
    assign w_sel_valid = (r_state == GRANT) && w_req_sel;
    assign w_handshake = w_sel_valid && s_if.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_burst_done <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            r_burst_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel      <= w_idx;
                        r_grant    <= onehot(w_idx);
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_handshake) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state      <= IDLE;
                            r_grant      <= '0;
                            r_ptr        <= r_sel + 1'b1;
                            r_burst_done <= 1'b1;
                            r_beat_cnt   <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end else if (!w_req_sel) begin
                        // Early release: partial burst abandoned, sel kept for a glitch-free mux.
                        r_state    <= IDLE;
                        r_grant    <= '0;
                        r_ptr      <= r_sel + 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_if.sel        = r_sel;
    assign s_if.grant      = r_grant;
    assign s_if.sel_valid  = w_sel_valid;
    assign s_if.burst_done = r_burst_done;

endmodule

// File: tb/tb_mux_rr_sel_sched.sv
// Directed bench for mux_rr_sel_sched with a grant scoreboard and an exhaustive rr_pick4 sweep.
module tb_mux_rr_sel_sched;
    import mux_sched_pkg::*;

    localparam int BL     = 4;
    localparam int BUDGET = 50;

    typedef struct {
        int ch;
        int beats;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sched_if sif ();

    mux_rr_sel_sched #(.BURST_LEN(BL)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (sif.slave)
    );

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic       pk_found;
    logic [1:0] pk_idx;

    rr_pick4 u_pick (
        .req   (pk_req),
        .ptr   (pk_ptr),
        .found (pk_found),
        .idx   (pk_idx)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next grant, pops its expectation, counts accepted beats until release.
    task automatic observe_grant();
        exp_t e;
        int   waited = 0;
        int   beats  = 0;
        while (sif.grant == '0 && waited < BUDGET) begin
            tick();
            waited++;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check("grant_latency", waited, 1);
        check("grant_onehot", sif.grant, 32'(1) << e.ch);
        check("grant_sel", sif.sel, e.ch);
        waited = 0;
        while (sif.grant != '0 && waited < BUDGET) begin
            if (sif.sel_valid && sif.out_ready) beats++;
            tick();
            waited++;
        end
        check($sformatf("beats_ch%0d", e.ch), beats, e.beats);
        check($sformatf("burst_done_ch%0d", e.ch), sif.burst_done, e.done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        sif.req       = '0;
        sif.out_ready = 1'b0;
        pk_req        = '0;
        pk_ptr        = '0;

        // Standalone rotating-priority pick, all 64 combinations.
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 16; r++) begin
                int exp_idx;
                bit exp_found;
                exp_found = 1'b0;
                exp_idx   = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!exp_found && r[(p + k) % 4]) begin
                        exp_found = 1'b1;
                        exp_idx   = (p + k) % 4;
                    end
                end
                pk_req = 4'(r);
                pk_ptr = 2'(p);
                #1;
                check($sformatf("pick_found p%0d r%0h", p, r), pk_found, exp_found);
                if (exp_found) check($sformatf("pick_idx p%0d r%0h", p, r), pk_idx, exp_idx);
            end
        end

        // Reset state.
        repeat (2) tick();
        check("rst_sel", sif.sel, 0);
        check("rst_grant", sif.grant, 0);
        check("rst_sel_valid", sif.sel_valid, 0);
        check("rst_burst_done", sif.burst_done, 0);
        rst = 1'b0;

        // Single requester: two full bursts on channel 2 with one bubble between.
        sif.req       = 4'b0100;
        sif.out_ready = 1'b1;
        #1;
        check("single_no_grant_yet", sif.grant, 0);
        exp_q.push_back('{ch: 2, beats: BL, done: 1'b1});
        exp_q.push_back('{ch: 2, beats: BL, done: 1'b1});
        observe_grant();
        check("single_bubble_grant", sif.grant, 0);
        check("single_bubble_valid", sif.sel_valid, 0);
        observe_grant();

        // Reset mid-burst with all requesting; ptr is 3 here so channel 3 wins first.
        sif.req = 4'b1111;
        tick();
        check("pre_rst_grant", sif.grant, 4'b1000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", sif.sel, 0);
        check("async_rst_grant", sif.grant, 0);
        check("async_rst_sel_valid", sif.sel_valid, 0);
        check("async_rst_burst_done", sif.burst_done, 0);
        tick();
        rst = 1'b0;

        // Fairness from ptr=0: 0,1,2,3,0, each a full burst.
        for (int c = 0; c < 5; c++) exp_q.push_back('{ch: c % 4, beats: BL, done: 1'b1});
        for (int c = 0; c < 5; c++) observe_grant();
        check("fair_scoreboard_drained", exp_q.size(), 0);
        sif.req = '0;
        tick();

        // Backpressure on channel 1 (ptr=1).
        sif.req       = 4'b0010;
        sif.out_ready = 1'b0;
        tick();
        check("bp_grant", sif.grant, 4'b0010);
        repeat (10) tick();
        check("bp_grant_hold", sif.grant, 4'b0010);
        check("bp_sel_valid", sif.sel_valid, 1);
        check("bp_no_done", sif.burst_done, 0);
        sif.out_ready = 1'b1;
        repeat (BL - 1) tick();
        check("bp_grant_before_last", sif.grant, 4'b0010);
        tick();
        check("bp_release", sif.grant, 0);
        check("bp_done", sif.burst_done, 1);

        // Early release on channel 3 (ptr=2, channel 2 idle so it is skipped).
        sif.req = 4'b1000;
        tick();
        check("er_grant", sif.grant, 4'b1000);
        check("er_sel", sif.sel, 3);
        repeat (2) tick();
        sif.req = 4'b0000;
        #1;
        check("er_valid_drop", sif.sel_valid, 0);
        check("er_grant_same_cycle", sif.grant, 4'b1000);
        tick();
        check("er_idle_grant", sif.grant, 0);
        check("er_no_done", sif.burst_done, 0);
        check("er_sel_held", sif.sel, 3);
        sif.req = 4'b0011;
        tick();
        check("er_next_grant", sif.grant, 4'b0001);
        check("er_next_sel", sif.sel, 0);

        // Drive ptr to 3 via two early releases, then wrap past 3 and 0 to channel 1.
        sif.req = 4'b0000;
        tick();
        sif.req = 4'b0100;
        tick();
        check("wrap_setup_grant", sif.grant, 4'b0100);
        sif.req = 4'b0000;
        tick();
        sif.req = 4'b0010;
        tick();
        check("wrap_grant", sif.grant, 4'b0010);
        check("wrap_sel", sif.sel, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
